// File: rtl/div_bcd_formatter.sv
// div_bcd_formatter
//   Sits after the 8-bit by 4-bit sequential divider. On a rising edge of the
//   divider's ready flag it captures quotient and remainder. It converts the
//   quotient to three BCD digits with a sequential double-dabble, one bit per
//   clock. The remainder digits are derived in a single step at capture time.
//   All outputs are registered. Digits change only when a conversion completes.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   ready_in  divider completion flag (level)
//   qu        divider quotient, sampled on the capture cycle only
//   rem       divider remainder, sampled on the capture cycle only
//   busy      conversion in progress
//   done      one-cycle pulse when new digits are valid
//   q_hund/q_tens/q_ones  quotient BCD digits
//   r_tens/r_ones         remainder BCD digits
//
// state | meaning
// IDLE  | waiting for a rising edge on ready_in
// SHIFT | double-dabble iterations, eight in total
module div_bcd_formatter (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_in,
  input  logic [7:0] qu,
  input  logic [3:0] rem,
  output logic       busy,
  output logic       done,
  output logic [3:0] q_hund,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic [3:0] r_tens,
  output logic [3:0] r_ones
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        ready_d;
  // {bcd[11:0], bin[7:0]}
  logic [19:0] sr, sr_nxt, sr_adj, sr_shift;
  logic [2:0]  cnt, cnt_nxt;
  logic [3:0]  rt_h, ro_h, rt_h_nxt, ro_h_nxt;
  logic        busy_nxt, done_nxt;
  logic [3:0]  q_hund_nxt, q_tens_nxt, q_ones_nxt, r_tens_nxt, r_ones_nxt;

  // Add-3 correction on every BCD nibble that is 5 or more, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[8+4*i +: 4] >= 4'd5)
        sr_adj[8+4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
    end
    sr_shift = {sr_adj[18:0], 1'b0};
  end

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    rt_h_nxt   = rt_h;
    ro_h_nxt   = ro_h;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    q_hund_nxt = q_hund;
    q_tens_nxt = q_tens;
    q_ones_nxt = q_ones;
    r_tens_nxt = r_tens;
    r_ones_nxt = r_ones;
    case (state)
      IDLE: begin
        if (ready_in && !ready_d) begin
          sr_nxt = {12'd0, qu};
          if (rem >= 4'd10) begin
            rt_h_nxt = 4'd1;
            ro_h_nxt = rem - 4'd10;
          end else begin
            rt_h_nxt = 4'd0;
            ro_h_nxt = rem;
          end
          cnt_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sr_nxt  = sr_shift;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          q_hund_nxt = sr_shift[19:16];
          q_tens_nxt = sr_shift[15:12];
          q_ones_nxt = sr_shift[11:8];
          r_tens_nxt = rt_h;
          r_ones_nxt = ro_h;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_d <= 1'b0;
      sr      <= '0;
      cnt     <= '0;
      rt_h    <= '0;
      ro_h    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q_hund  <= '0;
      q_tens  <= '0;
      q_ones  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
    end else begin
      state   <= state_nxt;
      ready_d <= ready_in;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      rt_h    <= rt_h_nxt;
      ro_h    <= ro_h_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      q_hund  <= q_hund_nxt;
      q_tens  <= q_tens_nxt;
      q_ones  <= q_ones_nxt;
      r_tens  <= r_tens_nxt;
      r_ones  <= r_ones_nxt;
    end
  end

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Self-checking bench for div_bcd_formatter. Expected digits come from plain
// decimal arithmetic on the captured quotient and remainder.
module tb_div_bcd_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready_in;
  logic [7:0] qu;
  logic [3:0] rem;
  logic       busy, done;
  logic [3:0] q_hund, q_tens, q_ones, r_tens, r_ones;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  div_bcd_formatter dut (
    .clk(clk), .rst(rst), .ready_in(ready_in), .qu(qu), .rem(rem),
    .busy(busy), .done(done), .q_hund(q_hund), .q_tens(q_tens),
    .q_ones(q_ones), .r_tens(r_tens), .r_ones(r_ones)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [19:0] model(input int q, input int r);
    model = {4'(q / 100), 4'((q / 10) % 10), 4'(q % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [19:0] digits();
    digits = {q_hund, q_tens, q_ones, r_tens, r_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen or the budget expires; n is the step count.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_in = 1'b0; qu = 8'd0; rem = 4'd0;
    step(); step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (digits() !== 20'h0) begin
      failures++;
      $display("FAIL reset_digits got %h required 00000", digits());
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_max();
    int busy_hi = 0;
    ready_in = 1'b1; qu = 8'd255; rem = 4'd15;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) begin qu = 8'd0; rem = 4'd0; end
      if (busy === 1'b1) busy_hi++;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL max_early_done step=%0d done=%b required 0", i, done);
      end
    end
    checks++;
    if (busy_hi != 8) begin
      failures++;
      $display("FAIL max_busy_cycles got %0d required 8", busy_hi);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL max_done done=%b busy=%b required 1 0", done, busy);
    end
    checks++;
    if (digits() !== model(255, 15)) begin
      failures++;
      $display("FAIL max_digits got %h required %h", digits(), model(255, 15));
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL max_done_width done=%b required 0", done);
    end
    ready_in = 1'b0;
    step();
  endtask

  task automatic test_sequence();
    int n;
    int d0 = done_cnt;
    ready_in = 1'b1; qu = 8'd100; rem = 4'd9;
    wait_done(20, n);
    checks++;
    if (n != 9 || digits() !== model(100, 9)) begin
      failures++;
      $display("FAIL seq_first lat=%0d got %h required lat 9 %h", n, digits(), model(100, 9));
    end
    ready_in = 1'b0;
    step();
    ready_in = 1'b1; qu = 8'd0; rem = 4'd0;
    wait_done(20, n);
    checks++;
    if (n != 9 || digits() !== model(0, 0)) begin
      failures++;
      $display("FAIL seq_second lat=%0d got %h required lat 9 %h", n, digits(), model(0, 0));
    end
    ready_in = 1'b0;
    step();
    checks++;
    if (done_cnt - d0 != 2) begin
      failures++;
      $display("FAIL seq_pulses got %0d required 2", done_cnt - d0);
    end
  endtask

  task automatic test_hold_high();
    int d0 = done_cnt;
    ready_in = 1'b1; qu = 8'd37; rem = 4'd10;
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL hold_pulses got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (digits() !== model(37, 10) || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_digits got %h busy=%b required %h busy=0", digits(), busy, model(37, 10));
    end
    ready_in = 1'b0;
    step();
  endtask

  task automatic test_ignored_edge();
    int d0 = done_cnt;
    ready_in = 1'b1; qu = 8'd199; rem = 4'd3;
    step();
    step(); step(); step();
    ready_in = 1'b0;
    step();
    ready_in = 1'b1; qu = 8'd42; rem = 4'd7;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL ignored_pulses got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (digits() !== model(199, 3)) begin
      failures++;
      $display("FAIL ignored_digits got %h required %h", digits(), model(199, 3));
    end
    ready_in = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    int d0 = done_cnt;
    ready_in = 1'b1; qu = 8'd128; rem = 4'd0;
    step();
    step(); step(); step(); step();
    rst = 1'b1; ready_in = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digits() !== 20'h0) begin
      failures++;
      $display("FAIL midreset_state busy=%b done=%b digits=%h required 0 0 00000", busy, done, digits());
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL midreset_no_done got %0d pulses required 0", done_cnt - d0);
    end
    ready_in = 1'b1;
    wait_done(20, n);
    checks++;
    if (n != 9 || digits() !== model(128, 0)) begin
      failures++;
      $display("FAIL midreset_retry lat=%0d got %h required lat 9 %h", n, digits(), model(128, 0));
    end
    ready_in = 1'b0;
    step();
  endtask

  task automatic test_ready_during_reset();
    int n;
    rst = 1'b1; ready_in = 1'b1; qu = 8'd64; rem = 4'd12;
    step(); step();
    rst = 1'b0;
    wait_done(20, n);
    checks++;
    if (n != 9 || digits() !== model(64, 12)) begin
      failures++;
      $display("FAIL ready_in_reset lat=%0d got %h required lat 9 %h", n, digits(), model(64, 12));
    end
    ready_in = 1'b0;
    step();
  endtask

  task automatic test_random();
    int n, q, r, gap;
    for (int k = 0; k < 25; k++) begin
      q = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 15));
      ready_in = 1'b1; qu = 8'(q); rem = 4'(r);
      step();
      qu = 8'($urandom); rem = 4'($urandom);
      wait_done(20, n);
      checks++;
      if (n != 8 || digits() !== model(q, r)) begin
        failures++;
        $display("FAIL random q=%0d r=%0d lat=%0d got %h required lat 8 %h", q, r, n, digits(), model(q, r));
      end
      ready_in = 1'b0;
      gap = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) step();
      checks++;
      if (digits() !== model(q, r)) begin
        failures++;
        $display("FAIL random_hold got %h required %h", digits(), model(q, r));
      end
    end
  endtask

  initial begin
    rst = 1'b1; ready_in = 1'b0; qu = 8'd0; rem = 4'd0;
    test_reset();
    test_max();
    test_sequence();
    test_hold_high();
    test_ignored_edge();
    test_reset_mid();
    test_ready_during_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
